// File: rtl/sys_bus.sv
// sys_bus: single-cycle system bus decoding CPU accesses to RAM, a machine timer and a UART TX FIFO.
// Build option SYS_BUS_TIMER_EN: when defined the timer is implemented, otherwise its window reads 0.
module sys_bus #(
  parameter logic [63:0] RAM_BASE   = 64'h0000_0000_8000_0000,
  parameter int unsigned RAM_AW     = 16,
  parameter logic [63:0] TIMER_BASE = 64'h0000_0000_0200_0000,
  parameter logic [63:0] UART_BASE  = 64'h0000_0000_1000_0000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TIMER_DIV  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        bus_rd_ctrl,
  input  logic [2:0]        bus_wr_ctrl,
  input  logic [63:0]       bus_addr,
  input  logic [63:0]       bus_din,
  output logic [63:0]       bus_dout,
  output logic              bus_err,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [63:0]       ram_wdata,
  output logic [7:0]        ram_wmask,
  output logic              ram_we,
  input  logic [63:0]       ram_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              timer_irq
);
  localparam int unsigned PW         = $clog2(FIFO_DEPTH);
  localparam int unsigned CW         = PW + 1;
  localparam logic [63:0] RAM_SIZE   = 64'd8 << RAM_AW;
  localparam logic [63:0] TIMER_SIZE = 64'h0000_0000_0001_0000;
  localparam logic [63:0] UART_SIZE  = 64'd8;

  logic        rd, wr, fetch, misalign, in_ram, in_tmr, in_uart, ok;
  logic [1:0]  sz;
  logic [2:0]  a;
  logic [7:0]  bmask, lsr;
  logic [63:0] raw, sh, ld, tmr_rdata;

  // Access decode: a simultaneous write is dropped in favour of the read.
  assign rd      = bus_rd_ctrl != 3'd0;
  assign wr      = !rd && (bus_wr_ctrl != 3'd0) && (bus_wr_ctrl <= 3'd4);
  assign fetch   = !rd && !wr;
  assign a       = bus_addr[2:0];
  assign in_ram  = (bus_addr - RAM_BASE) < RAM_SIZE;
  assign in_tmr  = (bus_addr - TIMER_BASE) < TIMER_SIZE;
  assign in_uart = (bus_addr - UART_BASE) < UART_SIZE;

  always_comb begin
    sz = 2'd3;
    if (rd) begin
      case (bus_rd_ctrl)
        3'd1, 3'd2: sz = 2'd0;
        3'd3, 3'd4: sz = 2'd1;
        3'd5, 3'd6: sz = 2'd2;
        default:    sz = 2'd3;
      endcase
    end else begin
      case (bus_wr_ctrl)
        3'd1:    sz = 2'd0;
        3'd2:    sz = 2'd1;
        3'd3:    sz = 2'd2;
        default: sz = 2'd3;
      endcase
    end
  end

  always_comb begin
    bmask = 8'hFF;
    case (sz)
      2'd0:    bmask = 8'h01 << a;
      2'd1:    bmask = 8'h03 << a;
      2'd2:    bmask = 8'h0F << a;
      default: bmask = 8'hFF;
    endcase
  end

  assign misalign = ((sz == 2'd1) && a[0]) || ((sz == 2'd2) && (a[1:0] != 2'd0)) ||
                    ((sz == 2'd3) && (a != 3'd0));
  assign bus_err  = (rd || wr) && (misalign || !(in_ram || in_tmr || in_uart));
  assign ok       = (rd || wr) && !bus_err;

  // Load path: pick the source doubleword, steer the lane down, then extend.
  always_comb begin
    raw = 64'd0;
    if (in_ram)                      raw = ram_rdata;
    else if (in_uart)                raw = {16'd0, lsr, 40'd0};
    else if (in_tmr && sz >= 2'd2)   raw = tmr_rdata;
  end

  assign sh = raw >> {a, 3'b000};

  always_comb begin
    ld = 64'd0;
    case (bus_rd_ctrl)
      3'd1:    ld = {{56{sh[7]}}, sh[7:0]};
      3'd2:    ld = {56'd0, sh[7:0]};
      3'd3:    ld = {{48{sh[15]}}, sh[15:0]};
      3'd4:    ld = {48'd0, sh[15:0]};
      3'd5:    ld = {{32{sh[31]}}, sh[31:0]};
      3'd6:    ld = {32'd0, sh[31:0]};
      3'd7:    ld = sh;
      default: ld = 64'd0;
    endcase
  end

  assign bus_dout  = fetch ? ram_rdata : ((rd && ok) ? ld : 64'd0);
  assign ram_addr  = bus_addr[RAM_AW+2:3];
  assign ram_wdata = bus_din << {a, 3'b000};
  assign ram_we    = rst && wr && ok && in_ram;
  assign ram_wmask = ram_we ? bmask : 8'h00;

  // UART TX FIFO; full is judged on pre-edge state so a full push drops even with a pop.
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count, count_nxt;
  logic          ovf, ovf_nxt, full, empty, push_req, push, pop, lsr_rd;

  assign full      = count == CW'(FIFO_DEPTH);
  assign empty     = count == CW'(0);
  assign lsr       = {1'b0, empty, !full, 3'b000, ovf, 1'b0};
  assign push_req  = wr && ok && in_uart && (bus_wr_ctrl == 3'd1) && (a == 3'd0);
  assign push      = push_req && !full;
  assign pop       = tx_valid && tx_ready;
  assign lsr_rd    = rd && ok && in_uart && bmask[5];
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign ovf_nxt   = (push_req && full) ? 1'b1 : (lsr_rd ? 1'b0 : ovf);
  assign tx_data   = mem[rptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[PW'(i)] <= 8'd0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      tx_valid <= 1'b0;
    end else begin
      if (push) begin
        mem[wptr] <= bus_din[7:0];
        wptr      <= wptr + PW'(1);
      end
      if (pop) rptr <= rptr + PW'(1);
      count    <= count_nxt;
      ovf      <= ovf_nxt;
      tx_valid <= count_nxt != CW'(0);
    end
  end

`ifdef SYS_BUS_TIMER_EN
  localparam int unsigned DW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

  logic [DW-1:0] presc;
  logic [63:0]   mtime, mtimecmp;
  logic [15:0]   tmr_off;
  logic          tick, sel_cmp, sel_time, tmr_wr;

  function automatic logic [63:0] merge(input logic [63:0] cur, input logic [63:0] din,
                                        input logic dword, input logic hi);
    if (dword) return din;
    if (hi)    return {din[31:0], cur[31:0]};
    return {cur[63:32], din[31:0]};
  endfunction

  assign tmr_off   = 16'(bus_addr - TIMER_BASE);
  assign sel_cmp   = tmr_off[15:3] == 13'h0800;
  assign sel_time  = tmr_off[15:3] == 13'h17FF;
  assign tmr_wr    = wr && ok && in_tmr && (sz >= 2'd2);
  assign tick      = presc == DW'(TIMER_DIV - 1);
  assign tmr_rdata = sel_cmp ? mtimecmp : (sel_time ? mtime : 64'd0);

  // A software write to mtime overrides the concurrent increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc     <= '0;
      mtime     <= 64'd0;
      mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
      timer_irq <= 1'b0;
    end else begin
      presc <= tick ? DW'(0) : presc + DW'(1);
      if (tmr_wr && sel_time)  mtime <= merge(mtime, bus_din, sz == 2'd3, a[2]);
      else if (tick)           mtime <= mtime + 64'd1;
      if (tmr_wr && sel_cmp)   mtimecmp <= merge(mtimecmp, bus_din, sz == 2'd3, a[2]);
      timer_irq <= mtime >= mtimecmp;
    end
  end
`else
  assign tmr_rdata = 64'd0;
  assign timer_irq = 1'b0;
`endif

endmodule

// File: doc/sys_bus.md
# sys_bus

Single-cycle system bus between the pipelined CPU's shared instruction/data port and its targets. It decodes each access to RAM, a machine timer or a UART transmit FIFO. It performs byte-lane steering, load sign/zero extension and store strobes. Reads return combinationally in the same cycle, so the CPU sees them as zero-wait-state accesses.

## Interface
Parameters:
- RAM_BASE, 64'h0000_0000_8000_0000, RAM window base; size is 8·2^RAM_AW bytes
- RAM_AW, 16, RAM doubleword-index width
- TIMER_BASE, 64'h0000_0000_0200_0000, timer window base (64 KiB)
- UART_BASE, 64'h0000_0000_1000_0000, UART window base (8 bytes)
- FIFO_DEPTH, 8, UART TX FIFO entries; must be a power of two and at least 2
- TIMER_DIV, 1, clocks per mtime increment; must be at least 1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- bus_rd_ctrl  in  3  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWU, 7 LD
- bus_wr_ctrl  in  3  0 none, 1 SB, 2 SH, 3 SW, 4 SD; 5–7 are treated as none
- bus_addr  in  64  byte address
- bus_din  in  64  store data, right-aligned
- bus_dout  out  64  load result, extended; raw ram_rdata when both ctrls are 0 (instruction fetch)
- bus_err  out  1  current access is misaligned or unmapped
- ram_addr  out  RAM_AW  bus_addr[RAM_AW+2:3]
- ram_wdata  out  64  store data shifted to its byte lane
- ram_wmask  out  8  byte strobes
- ram_we  out  1  RAM write enable
- ram_rdata  in  64  RAM asynchronous read data
- tx_data  out  8  head of the FIFO
- tx_valid  out  1  FIFO not empty
- tx_ready  in  1  consumer accepts the head byte
- timer_irq  out  1  high while mtime ≥ mtimecmp (unsigned compare)

## Operation
- Decode: an access is in a window when bus_addr lies in [base, base+size). Any address outside all windows is unmapped.
- A read and a write asserted together is illegal: the write is dropped and the read proceeds.
- Alignment: halfword accesses need addr[0]=0, words addr[1:0]=0, doublewords addr[2:0]=0.
- Error cases (misaligned or unmapped):
  - bus_err=1 for that cycle;
  - bus_dout=0;
  - no state changes.
- Loads: select the byte lane by addr[2:0], then sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU) to 64 bits.
- Stores: ram_wmask is 8'h01<<a for SB, 8'h03<<a for SH, 8'h0F<<a for SW and 8'hFF for SD. ram_we=1 only for an aligned RAM store.
- Timer (offsets from TIMER_BASE):
  - mtimecmp at +0x4000, mtime at +0xBFF8.
  - Only SD/LD and SW/LW/LWU with byte-lane merge are supported.
  - mtime increments when a prescaler counter reaches TIMER_DIV−1; the prescaler then returns to 0.
- UART (offsets from UART_BASE):
  - +0 THR, write-only; SB pushes bus_din[7:0].
  - +5 LSR, read-only: bit5 = FIFO not full, bit6 = FIFO empty, bit1 = sticky overflow; all other bits 0.
  - Reads of THR and writes to LSR return 0 / are ignored.
- FIFO:
  - A pop occurs when tx_valid && tx_ready.
  - A push while full is dropped and sets overflow. The full check uses pre-edge state, so a push is still dropped when a pop occurs in the same cycle.
  - Push and pop in the same non-full, non-empty cycle keep the count unchanged.
  - A read of LSR clears overflow on that edge. An overflow event in the same cycle wins, leaving the bit set.
  - Pointers are log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH. A separate count of log2(FIFO_DEPTH)+1 bits distinguishes full from empty.

## Timing
- All read paths are combinational: bus_dout and bus_err settle in the access cycle.
- Register, timer and FIFO writes take effect at the next rising clk.
- Reset values:
  - mtime=0, prescaler=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF (so timer_irq=0);
  - FIFO empty with pointers 0, overflow=0;
  - tx_valid=0, tx_data=0, ram_we=0, ram_wmask=0.
- A software write to mtime in the same cycle as an increment wins; mtime takes the written value.
- timer_irq is registered and updates one clk after mtime or mtimecmp changes.
- A push into an empty FIFO raises tx_valid on the following clk.
- Reset mid-operation discards FIFO contents immediately (asynchronous).

## Configuration
- SYS_BUS_TIMER_EN defined: the timer is implemented as described above.
- SYS_BUS_TIMER_EN undefined:
  - the TIMER window still decodes, so no bus_err;
  - reads return 0 and writes are ignored;
  - timer_irq is tied to 0;
  - no timer flops are instantiated.

## Test plan
- RAM store/load: SB 0xAB at RAM_BASE+3 → ram_wmask=8'h08, ram_wdata[31:24]=8'hAB. Then LB from RAM_BASE+3 with ram_rdata[31:24]=8'hAB → bus_dout=64'hFFFF_FFFF_FFFF_FFAB; LBU → 64'h0000_0000_0000_00AB.
- Misaligned/unmapped: LW at RAM_BASE+2 → bus_err=1, bus_dout=0, ram_we=0. SD to 0x0 → bus_err=1.
- FIFO flow control: hold tx_ready=0 and push 9 bytes with FIFO_DEPTH=8 → LSR reads 8'h02 (full, overflow set). A second LSR read → 8'h00. Release tx_ready → bytes 1–8 drain in order, then LSR=8'h60.
- Simultaneous FIFO events: with the FIFO full, push and pop in the same cycle → push dropped, overflow=1, count=7.
- Timer: write mtimecmp=5 with TIMER_DIV=1 → timer_irq rises one clk after mtime reaches 5. A write of mtime=0 coinciding with an increment → mtime reads 0.
- Reset: assert rst low mid-drain with 3 bytes queued → tx_valid falls immediately; after release, LSR=8'h60.
